// File: rtl/ctrl_sequencer_if.sv
// Control bus between the hardwired sequencer and the IR / register-file select-encode logic.
// The slave modport is the sequencer side; master is the datapath/environment side.
interface ctrl_sequencer_if #(
    parameter int BITS = 32
);
    logic            run;
    logic [BITS-1:0] IR;
    logic            mem_ready;
    logic            step;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic Yin, Zin, Zlowout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;

    logic [3:0] alu_op;
    logic       busy;
    logic       halted;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  run, IR, mem_ready, step,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        output Yin, Zin, Zlowout, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_op, busy, halted, illegal, state
    );

    modport master (
        output run, IR, mem_ready, step,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
        input  Yin, Zin, Zlowout, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_op, busy, halted, illegal, state
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the R-type / immediate ALU subset plus nop and halt.
// Optional single-step mode (WAIT state after each instruction) is enabled by defining STEP_EN.
module ctrl_sequencer #(
    parameter int BITS     = 32,
    parameter int OPC_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    ctrl_sequencer_if.slave     bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_HALT = 4'd7,
        S_WAIT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_INC4 = 4'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_IMM,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    localparam logic [OPC_BITS-1:0] OP_ADD  = OPC_BITS'(5'b00011);
    localparam logic [OPC_BITS-1:0] OP_SUB  = OPC_BITS'(5'b00100);
    localparam logic [OPC_BITS-1:0] OP_AND  = OPC_BITS'(5'b00101);
    localparam logic [OPC_BITS-1:0] OP_OR   = OPC_BITS'(5'b00110);
    localparam logic [OPC_BITS-1:0] OP_ADDI = OPC_BITS'(5'b01100);
    localparam logic [OPC_BITS-1:0] OP_ANDI = OPC_BITS'(5'b01101);
    localparam logic [OPC_BITS-1:0] OP_ORI  = OPC_BITS'(5'b01110);
    localparam logic [OPC_BITS-1:0] OP_NOP  = OPC_BITS'(5'b11000);
    localparam logic [OPC_BITS-1:0] OP_HALT = OPC_BITS'(5'b11001);

    state_t              state_q;
    logic                illegal_q;
    logic [OPC_BITS-1:0] opcode;
    op_class_t           op_class;
    alu_op_t             op_alu;
    state_t              next_instr;
    state_t              after_instr;

    assign opcode = bus.IR[BITS-1 -: OPC_BITS];

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        op_class = C_ILLEGAL;
        op_alu   = ALU_PASS;
        case (opcode)
            OP_ADD:  begin op_class = C_RTYPE; op_alu = ALU_ADD; end
            OP_SUB:  begin op_class = C_RTYPE; op_alu = ALU_SUB; end
            OP_AND:  begin op_class = C_RTYPE; op_alu = ALU_AND; end
            OP_OR:   begin op_class = C_RTYPE; op_alu = ALU_OR;  end
            OP_ADDI: begin op_class = C_IMM;   op_alu = ALU_ADD; end
            OP_ANDI: begin op_class = C_IMM;   op_alu = ALU_AND; end
            OP_ORI:  begin op_class = C_IMM;   op_alu = ALU_OR;  end
            OP_NOP:  op_class = C_NOP;
            OP_HALT: op_class = C_HALT;
            default: op_class = C_ILLEGAL;
        endcase
    end

    assign next_instr = bus.run ? S_T0 : S_IDLE;

`ifdef STEP_EN
    assign after_instr = S_WAIT;
`else
    assign after_instr = next_instr;
    logic unused_step;
    assign unused_step = bus.step;
`endif

    // Only the opcode field is decoded; operand fields pass straight to the select/encode logic.
    logic unused_ir;
    assign unused_ir = ^bus.IR[BITS-OPC_BITS-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.run) state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   if (bus.mem_ready) state_q <= S_T2;
                S_T2:   state_q <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_RTYPE, C_IMM: state_q <= S_T4;
                        C_NOP:          state_q <= after_instr;
                        C_HALT:         state_q <= S_HALT;
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_HALT;
                        end
                    endcase
                end
                S_T4:   state_q <= S_T5;
                S_T5:   state_q <= after_instr;
`ifdef STEP_EN
                S_WAIT: if (bus.step) state_q <= next_instr;
`endif
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from the state register and the opcode only.
    always_comb begin
        bus.PCout   = 1'b0;
        bus.PCin    = 1'b0;
        bus.IncPC   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Read    = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.Cout    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.alu_op  = ALU_PASS;
        case (state_q)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_INC4;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (op_class == C_RTYPE || op_class == C_IMM) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Zin    = 1'b1;
                bus.alu_op = op_alu;
                if (op_class == C_IMM) begin
                    bus.Cout = 1'b1;
                end else begin
                    bus.Grc  = 1'b1;
                    bus.Rout = 1'b1;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.BAout   = 1'b0;
    assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted  = (state_q == S_HALT);
    assign bus.illegal = illegal_q;
    assign bus.state   = state_q;

endmodule
